mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mem_en, input, 1, MEM-stage instruction accesses memory.
REQ-005 The block SHALL have port mem_wr, input, 1, 1=store, 0=load.
REQ-006 The block SHALL have port size_con, input, 2, access size: 01 word, 10 half, 11 byte, 00 no-op.
REQ-007 The block SHALL have ports addr and wdata, input, 32 each, byte address and unaligned store data.
REQ-008 The block SHALL have port flush, input, 1, pipeline flush of the MEM-stage instruction.
REQ-009 The block SHALL have bus outputs data_req (1), data_wr (1), data_size (2), data_addr (32), data_wstrb (4), data_wdata (32).
REQ-010 The block SHALL have bus inputs data_addr_ok (1), data_data_ok (1), data_rdata (32).
REQ-011 The block SHALL have outputs stall (1), done (1), rdata_out (32), adel (1, load address error), ades (1, store address error).

Function
REQ-012 Alignment: word needs addr[1:0]=00, half needs addr[0]=0, byte is always aligned.
REQ-013 A misaligned access SHALL assert adel (load) or ades (store) combinationally the same cycle, issue no bus request and keep stall low; both SHALL be 0 when mem_en=0, size_con=00 or flush=1.
REQ-014 Strobe SHALL be 1111 for a word; 0011 or 1100 for a half (addr[1]=0/1); 0001 shifted left by addr[1:0] for a byte; 0000 for any load.
REQ-015 Write data SHALL be wdata for a word, {2{wdata[15:0]}} for a half, {4{wdata[7:0]}} for a byte.
REQ-016 data_size SHALL be 2 for a word, 1 for a half, 0 for a byte; data_addr SHALL equal the captured addr unmodified.
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: on mem_en=1, size_con!=00, aligned and flush=0, the block SHALL register wr/size/addr/strobe/data, assert stall combinationally the same cycle, and move to REQ.
REQ-019 REQ: data_req=1 with all bus fields held stable from the registered copy; on data_addr_ok=1 go to WAIT, or straight to DONE when data_data_ok=1 in the same cycle.
REQ-020 WAIT: data_req=0; on data_data_ok=1 capture data_rdata into rdata_out and go to DONE.
REQ-021 DONE: one cycle only; stall=0 and done=1; rdata_out valid (loads); inputs are ignored; the next state is always IDLE.
REQ-022 stall SHALL be 1 in REQ and WAIT, and in IDLE during an accepting cycle; it SHALL be 0 otherwise.
REQ-023 A store SHALL latch rdata_out as well; rdata_out SHALL hold its value until the next data_data_ok.
REQ-024 Minimum latency SHALL be accept in cycle 0, addr_ok+data_ok in cycle 1, done in cycle 2.
REQ-025 A flush in REQ or WAIT SHALL set a drop flag; the bus transaction SHALL still complete (data_req never retracted before addr_ok).
REQ-026 With the drop flag set, DONE SHALL output done=0 and leave rdata_out unchanged; the flag SHALL clear on leaving DONE.
REQ-027 data_data_ok in IDLE or DONE, or data_addr_ok outside REQ, SHALL be ignored.

Reset
REQ-028 While rst=1 the FSM SHALL be in IDLE; data_req, stall, done, adel, ades, data_wstrb, rdata_out and all captured registers SHALL be 0; the drop flag SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately with no completion signalled.

Verification
REQ-030 SB with addr=0x1003, wdata=0x000000AB, addr_ok+data_ok next cycle -> data_wstrb=1000, data_wdata=0xABABABAB, data_size=0; done in cycle 2.
REQ-031 SH with addr=0x1001 -> ades=1 that cycle, data_req never rises, stall=0; LW with addr=0x1002 -> adel=1.
REQ-032 LW with addr=0x2000, addr_ok delayed 3 cycles and data_ok 2 more with data_rdata=0xDEADBEEF -> stall high 6 cycles, then done=1 with rdata_out=0xDEADBEEF.
REQ-033 SW with flush asserted in WAIT -> bus completes, done stays 0, rdata_out is unchanged, and the next access is accepted after DONE.
REQ-034 rst pulsed while in WAIT -> all outputs 0 and IDLE immediately; a new SW afterwards behaves as in REQ-024.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller and the memory port.
// The controller is the master; the memory side answers with addr_ok/data_ok.
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment check, lane steering, and a
// request/wait/done handshake with the data bus that stalls the pipeline.
module mem_access_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic                mem_wr,
    input  logic [1:0]          size_con,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic                flush,
    mem_access_ctrl_if.master   bus,
    output logic                stall,
    output logic                done,
    output logic [31:0]         rdata_out,
    output logic                adel,
    output logic                ades
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } size_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        drop_q, drop_d;

    logic        active;
    logic        misaligned;
    logic        accept;
    logic        capture_ok;

    assign active     = mem_en && (size_con != SZ_NONE) && !flush;
    assign misaligned = ((size_con == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                        ((size_con == SZ_HALF) && addr[0]);
    // Inputs only matter in IDLE; gating with rst keeps outputs quiet in reset.
    assign accept     = !rst && (state_q == IDLE) && active && !misaligned;
    assign adel       = !rst && (state_q == IDLE) && active && misaligned && !mem_wr;
    assign ades       = !rst && (state_q == IDLE) && active && misaligned && mem_wr;

    // A flush arriving in the same cycle as data_ok must already suppress capture.
    assign capture_ok = !(drop_q || flush);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        drop_d  = drop_q;
        stall   = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    stall   = 1'b1;
                    wr_d    = mem_wr;
                    addr_d  = addr;
                    case (size_con)
                        SZ_WORD: begin
                            size_d  = 2'd2;
                            strb_d  = 4'b1111;
                            wdata_d = wdata;
                        end
                        SZ_HALF: begin
                            size_d  = 2'd1;
                            strb_d  = addr[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{wdata[15:0]}};
                        end
                        default: begin
                            size_d  = 2'd0;
                            strb_d  = 4'b0001 << addr[1:0];
                            wdata_d = {4{wdata[7:0]}};
                        end
                    endcase
                    if (!mem_wr) begin
                        strb_d = '0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d = DONE;
                        if (capture_ok) begin
                            rdata_d = bus.data_rdata;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (bus.data_data_ok) begin
                    state_d = DONE;
                    if (capture_ok) begin
                        rdata_d = bus.data_rdata;
                    end
                end
            end
            DONE: begin
                done    = !drop_q;
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.data_req   = (state_q == REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wstrb = strb_q;
    assign bus.data_wdata = wdata_q;
    assign rdata_out      = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses with
// random bus latency, flushes and resets, checked against a transaction model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en, mem_wr, flush;
    logic [1:0]  size_con;
    logic [31:0] addr, wdata;
    logic        stall, done, adel, ades;
    logic [31:0] rdata_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] rdata_exp = '0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .size_con  (size_con),
        .addr      (addr),
        .wdata     (wdata),
        .flush     (flush),
        .bus       (bus),
        .stall     (stall),
        .done      (done),
        .rdata_out (rdata_out),
        .adel      (adel),
        .ades      (ades)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: bytes touched and lane contents from the access geometry.
    function automatic int unsigned nbytes(input logic [1:0] sz);
        case (sz)
            2'b01:   return 4;
            2'b10:   return 2;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_strobe(input logic wr, input logic [31:0] a, input int unsigned n);
        logic [3:0]  s;
        int unsigned off;
        s   = '0;
        off = a % 4;
        if (wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (i >= off && i < off + n) s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[8*i +: 8] = 8'(wd >> (8 * (i % n)));
        end
        return r;
    endfunction

    task automatic drive_cpu(input logic en, input logic wr, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input logic fl);
        mem_en   = en;
        mem_wr   = wr;
        size_con = sz;
        addr     = a;
        wdata    = wd;
        flush    = fl;
    endtask

    task automatic drive_bus_random();
        bus.data_addr_ok = 1'($urandom_range(0, 1));
        bus.data_data_ok = 1'($urandom_range(0, 1));
        bus.data_rdata   = $urandom;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_req"},   32'(bus.data_req),   '0);
        check_val({tag, "_wr"},    32'(bus.data_wr),    '0);
        check_val({tag, "_size"},  32'(bus.data_size),  '0);
        check_val({tag, "_addr"},  bus.data_addr,       '0);
        check_val({tag, "_wstrb"}, 32'(bus.data_wstrb), '0);
        check_val({tag, "_wdata"}, bus.data_wdata,      '0);
        check_val({tag, "_stall"}, 32'(stall),          '0);
        check_val({tag, "_done"},  32'(done),           '0);
        check_val({tag, "_adel"},  32'(adel),           '0);
        check_val({tag, "_ades"},  32'(ades),           '0);
        check_val({tag, "_rdata"}, rdata_out,           '0);
    endtask

    // Called at a negedge; returns at a negedge. a_lat = REQ cycles before the
    // one carrying addr_ok, d_lat = cycles from addr_ok to data_ok.
    // flush_at/rst_at: cycle index relative to the accept cycle, -1 for none.
    task automatic run_access(input logic en, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a_in, input logic [31:0] wd, input logic [31:0] rd_val,
                              input int a_lat, input int d_lat, input int flush_at, input int rst_at);
        int unsigned n;
        bit          live, mis, takes, dropped, in_req;
        int          t_done, ok_cyc;
        logic [1:0]  g_sz;

        n     = nbytes(sz);
        live  = en && (n != 0) && (flush_at != 0);
        mis   = 1'b0;
        if (live) mis = (a_in % n) != 0;
        takes = live && !mis;

        if (!takes) begin
            drive_cpu(en, wr, sz, a_in, wd, flush_at == 0);
            drive_bus_random();
            #1;
            check_val("nop_stall", 32'(stall),        '0);
            check_val("nop_req",   32'(bus.data_req), '0);
            check_val("nop_done",  32'(done),         '0);
            check_val("adel",      32'(adel),         32'(mis && !wr));
            check_val("ades",      32'(ades),         32'(mis && wr));
            check_val("nop_rdata", rdata_out,         rdata_exp);
            @(negedge clk);
            return;
        end

        t_done  = a_lat + d_lat + 2;
        ok_cyc  = a_lat + 1 + d_lat;
        dropped = (flush_at >= 1) && (flush_at < t_done);

        for (int k = 0; k <= t_done; k++) begin
            in_req = (k >= 1) && (k <= a_lat + 1);
            if (k == rst_at) begin
                rst = 1'b1;
                drive_cpu(1'b1, wr, sz, a_in, wd, 1'b0);
                drive_bus_random();
                #1;
                check_reset("rst_mid");
                rdata_exp = '0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k < t_done) begin
                drive_cpu(en, wr, sz, a_in, wd, k == flush_at);
            end else begin
                g_sz = 2'($urandom);
                drive_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g_sz,
                          $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            bus.data_addr_ok = in_req ? (k == a_lat + 1) : 1'($urandom_range(0, 1));
            bus.data_data_ok = (k == ok_cyc) ? 1'b1 :
                               ((k == 0 || k == t_done) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.data_rdata   = (k == ok_cyc) ? rd_val : $urandom;
            #1;
            check_val("stall", 32'(stall),        32'(k < t_done));
            check_val("req",   32'(bus.data_req), 32'(in_req));
            check_val("done",  32'(done),         32'((k == t_done) && !dropped));
            check_val("adel",  32'(adel),         '0);
            check_val("ades",  32'(ades),         '0);
            if (in_req) begin
                check_val("bus_addr",  bus.data_addr,       a_in);
                check_val("bus_wr",    32'(bus.data_wr),    32'(wr));
                check_val("bus_size",  32'(bus.data_size),  32'($clog2(n)));
                check_val("bus_wstrb", 32'(bus.data_wstrb), 32'(exp_strobe(wr, a_in, n)));
                check_val("bus_wdata", bus.data_wdata,      exp_wdata(wd, n));
            end
            if (k == t_done && !dropped) rdata_exp = rd_val;
            if (k == 0 || k == t_done) check_val("rdata_out", rdata_out, rdata_exp);
            @(negedge clk);
        end
    endtask

    initial begin
        int a, d, fa, ra, sel;
        drive_cpu(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        #1;
        rst = 1'b1;
        drive_cpu(1'b1, 1'b1, 2'b01, 32'h100, 32'h1234, 1'b0);
        #2;
        check_reset("rst_init");
        @(negedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        rdata_exp = '0;

        // SB to the top lane with single-cycle bus response
        run_access(1'b1, 1'b1, 2'b11, 32'h1003, 32'h000000AB, 32'h55AA55AA, 0, 0, -1, -1);
        // misaligned SH and LW
        run_access(1'b1, 1'b1, 2'b10, 32'h1001, 32'h0, 32'h0, 0, 0, -1, -1);
        run_access(1'b1, 1'b0, 2'b01, 32'h1002, 32'h0, 32'h0, 0, 0, -1, -1);
        // slow LW
        run_access(1'b1, 1'b0, 2'b01, 32'h2000, 32'h0, 32'hDEADBEEF, 2, 2, -1, -1);
        // SW flushed in WAIT, then an immediate follow-on access
        run_access(1'b1, 1'b1, 2'b01, 32'h3000, 32'hCAFEF00D, 32'h11112222, 0, 2, 2, -1);
        run_access(1'b1, 1'b0, 2'b10, 32'h3002, 32'h0, 32'h0BADF00D, 0, 1, -1, -1);
        // reset in WAIT, then a minimum-latency SW
        run_access(1'b1, 1'b1, 2'b01, 32'h4000, 32'h12345678, 32'h99999999, 0, 3, -1, 2);
        run_access(1'b1, 1'b1, 2'b01, 32'h4004, 32'h87654321, 32'h76543210, 0, 0, -1, -1);
        // no-op encodings
        run_access(1'b0, 1'b0, 2'b01, 32'h5001, 32'h0, 32'h0, 0, 0, -1, -1);
        run_access(1'b1, 1'b1, 2'b00, 32'h5003, 32'h0, 32'h0, 0, 0, -1, -1);
        run_access(1'b1, 1'b1, 2'b01, 32'h5002, 32'h0, 32'h0, 0, 0, 0, -1);

        for (int i = 0; i < 400; i++) begin
            a   = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            fa  = (sel == 0) ? 0 : ((sel == 1) ? int'($urandom_range(1, a + d + 1)) : -1);
            ra  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, a + d + 2)) : -1;
            run_access($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 2'($urandom),
                       $urandom, $urandom, $urandom, a, d, fa, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
